// File: rtl/regfile_param_pkg.sv
// regfile_param_pkg: shared constants and helpers for the register file
package regfile_param_pkg;
  localparam int BYTE_W   = 8;
  localparam int ZERO_IDX = 0;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/regfile_param_if.sv
// regfile_param_if: write port and two read ports of the register file
interface regfile_param_if import regfile_param_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int AW = addr_w(DEPTH);
  logic                    we;
  logic [AW-1:0]           waddr;
  logic [WIDTH-1:0]        wdata;
  logic [WIDTH/BYTE_W-1:0] wstrb;
  logic [AW-1:0]           raddr1;
  logic [AW-1:0]           raddr2;
  logic [WIDTH-1:0]        rdata1;
  logic [WIDTH-1:0]        rdata2;
  modport master (output we, waddr, wdata, wstrb, raddr1, raddr2, input rdata1, rdata2);
  modport slave  (input we, waddr, wdata, wstrb, raddr1, raddr2, output rdata1, rdata2);
endinterface

// File: rtl/regfile_param_entry.sv
// regfile_entry: one storage word with async reset and byte-strobed write
module regfile_entry import regfile_param_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic [WIDTH/BYTE_W-1:0] i_strb,
  input  logic [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_q
);
  logic [WIDTH-1:0] r_q;
  // clear on reset, otherwise overwrite only the strobed bytes when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else if (i_en)
      for (int b = 0; b < WIDTH/BYTE_W; b++)
        if (i_strb[b]) r_q[b*BYTE_W +: BYTE_W] <= i_wdata[b*BYTE_W +: BYTE_W];
  end
  assign o_q = r_q;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: DEPTH x WIDTH register file, strobed write port, two combinational read ports
module regfile_param import regfile_param_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1,
  parameter bit BYPASS   = 1
) (
  input logic            clk,
  input logic            rst,
  regfile_param_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  localparam int NB = WIDTH / BYTE_W;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (WIDTH % BYTE_W != 0 || DEPTH < 2 || DEPTH > 256) begin : g_bad_params
    $error("regfile_param: WIDTH must be a multiple of 8 and DEPTH within 2..256");
  end

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  logic [WIDTH-1:0] w_q [DEPTH];

  // one entry per address; the zero slot is a constant when enabled, and an
  // out-of-range write address simply matches no entry
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    if (ZERO_REG && i == ZERO_IDX) begin : g_zero
      assign w_q[i] = '0;
    end else begin : g_reg
      regfile_entry #(.WIDTH(WIDTH)) u_entry (
        .clk     (clk),
        .rst     (rst),
        .i_en    (bus.we && bus.waddr == AW'(i)),
        .i_strb  (bus.wstrb),
        .i_wdata (bus.wdata),
        .o_q     (w_q[i])
      );
    end
  end

  logic [WIDTH-1:0] w_old, w_new;
  logic             w_byp, w_in1, w_in2;

  // post-write value of the addressed entry and the bypass qualifier; reset suppresses bypass
  always_comb begin
    w_old = in_range(bus.waddr) ? w_q[bus.waddr] : '0;
    w_new = w_old;
    for (int b = 0; b < NB; b++)
      if (bus.wstrb[b]) w_new[b*BYTE_W +: BYTE_W] = bus.wdata[b*BYTE_W +: BYTE_W];
    w_byp = BYPASS && !rst && bus.we && in_range(bus.waddr) &&
            !(ZERO_REG && bus.waddr == AW'(ZERO_IDX));
    w_in1 = in_range(bus.raddr1);
    w_in2 = in_range(bus.raddr2);
  end

  // read muxes: zero under reset or out of range, merged word on a bypass hit
  always_comb begin
    bus.rdata1 = (rst || !w_in1) ? '0 :
                 (w_byp && bus.raddr1 == bus.waddr) ? w_new : w_q[bus.raddr1];
    bus.rdata2 = (rst || !w_in2) ? '0 :
                 (w_byp && bus.raddr2 == bus.waddr) ? w_new : w_q[bus.raddr2];
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: random and directed checks of three regfile_param configurations against an array model
module tb_regfile_param;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;

  logic        we = 0;
  logic [4:0]  waddr = 0, r1 = 0, r2 = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        cwe = 0;
  logic [2:0]  cwaddr = 0, cr1 = 0, cr2 = 0;
  logic [63:0] cwdata = 0;
  logic [7:0]  cwstrb = 0;

  logic [63:0] ma [32];
  logic [63:0] mb [20];
  logic [63:0] mc [8];
  int n_tests = 0, n_fail = 0;

  regfile_param_if #(.WIDTH(32), .DEPTH(32)) ifa ();
  regfile_param_if #(.WIDTH(32), .DEPTH(20)) ifb ();
  regfile_param_if #(.WIDTH(64), .DEPTH(8))  ifc ();

  assign ifa.we = we;     assign ifa.waddr = waddr; assign ifa.wdata = wdata;
  assign ifa.wstrb = wstrb; assign ifa.raddr1 = r1; assign ifa.raddr2 = r2;
  assign ifb.we = we;     assign ifb.waddr = waddr; assign ifb.wdata = wdata;
  assign ifb.wstrb = wstrb; assign ifb.raddr1 = r1; assign ifb.raddr2 = r2;
  assign ifc.we = cwe;    assign ifc.waddr = cwaddr; assign ifc.wdata = cwdata;
  assign ifc.wstrb = cwstrb; assign ifc.raddr1 = cr1; assign ifc.raddr2 = cr2;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  regfile_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  regfile_param #(.WIDTH(64), .DEPTH(8),  .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] st, input int a, input int depth,
      input bit z, input bit byp, input bit w, input int wa, input logic [63:0] d, input logic [7:0] s);
    if (rst || a >= depth || (z && a == 0)) return 64'h0;
    if (byp && w && a == wa) return merge(st, d, s);
    return st;
  endfunction

  function automatic logic [63:0] exp_a(input int a);
    return ref_rd(ma[a], a, 32, 1, 1, we, int'(waddr), {32'h0, wdata}, {4'h0, wstrb});
  endfunction
  function automatic logic [63:0] exp_b(input int a);
    return ref_rd((a < 20) ? mb[a] : 64'h0, a, 20, 0, 0, we, int'(waddr), {32'h0, wdata}, {4'h0, wstrb});
  endfunction
  function automatic logic [63:0] exp_c(input int a);
    return ref_rd(mc[a], a, 8, 1, 1, cwe, int'(cwaddr), cwdata, cwstrb);
  endfunction

  task automatic clear_model();
    foreach (ma[i]) ma[i] = 0;
    foreach (mb[i]) mb[i] = 0;
    foreach (mc[i]) mc[i] = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a1"}, {32'h0, ifa.rdata1}, exp_a(int'(r1)));
    check({tag, ".a2"}, {32'h0, ifa.rdata2}, exp_a(int'(r2)));
    check({tag, ".b1"}, {32'h0, ifb.rdata1}, exp_b(int'(r1)));
    check({tag, ".b2"}, {32'h0, ifb.rdata2}, exp_b(int'(r2)));
    check({tag, ".c1"}, ifc.rdata1, exp_c(int'(cr1)));
    check({tag, ".c2"}, ifc.rdata2, exp_c(int'(cr2)));
  endtask

  // commit the current write inputs to the model, then advance one edge
  task automatic cycle();
    if (!rst) begin
      if (we && waddr != 0) ma[waddr] = merge(ma[waddr], {32'h0, wdata}, {4'h0, wstrb});
      if (we && waddr < 20) mb[waddr] = merge(mb[waddr], {32'h0, wdata}, {4'h0, wstrb});
      if (cwe && cwaddr != 0) mc[cwaddr] = merge(mc[cwaddr], cwdata, cwstrb);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we = 1; waddr = a; wdata = d; wstrb = s;
    cycle();
    we = 0;
  endtask

  initial begin
    clear_model();
    @(posedge clk); #1;
    check_all("por");
    rst = 0;
    cycle();

    for (int i = 1; i < 32; i++) wr(5'(i), {8'(i), 8'hA5, 8'(i), 8'h3C}, 4'hF);
    r1 = 5; r2 = 31; #1;
    check("load5", {32'h0, ifa.rdata1}, 64'h05A5053C);
    check_all("load");
    we = 1; waddr = 5; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    #1 rst = 1;
    clear_model();
    #1;
    check("rst_mid.a1", {32'h0, ifa.rdata1}, 64'h0);
    for (int i = 0; i < 32; i++) begin
      r1 = 5'(i); r2 = 5'(31 - i); waddr = 5'(i);
      #1 check_all("rst_hold");
      cycle();
    end
    rst = 0; we = 0;
    repeat (3) cycle();
    r1 = 5; r2 = 5; #1;
    check("rst_after.a", {32'h0, ifa.rdata1}, 64'h0);
    check("rst_after.b", {32'h0, ifb.rdata2}, 64'h0);

    wr(7, 32'h11223344, 4'hF);
    we = 1; waddr = 7; wdata = 32'hAABBCCDD; wstrb = 4'b0101; r1 = 7; r2 = 7;
    cycle();
    we = 0; #1;
    check("strb.a", {32'h0, ifa.rdata1}, 64'h11BB33DD);
    check("strb.b", {32'h0, ifb.rdata2}, 64'h11BB33DD);
    we = 1; wdata = 32'hFFFFFFFF; wstrb = 4'h0;
    cycle();
    we = 0; #1;
    check("strb0.a", {32'h0, ifa.rdata1}, 64'h11BB33DD);
    check("strb0.b", {32'h0, ifb.rdata1}, 64'h11BB33DD);

    we = 1; waddr = 0; wdata = 32'hDEADBEEF; wstrb = 4'hF; r1 = 0; r2 = 0; #1;
    check("zero_wr.a1", {32'h0, ifa.rdata1}, 64'h0);
    check("zero_wr.a2", {32'h0, ifa.rdata2}, 64'h0);
    cycle();
    we = 0; #1;
    check("zero_after.a1", {32'h0, ifa.rdata1}, 64'h0);
    check("zero_after.a2", {32'h0, ifa.rdata2}, 64'h0);
    check("zero_after.b", {32'h0, ifb.rdata1}, 64'hDEADBEEF);

    wr(3, 32'h0, 4'hF);
    we = 1; waddr = 3; wdata = 32'h12345678; wstrb = 4'b0011; r1 = 3; r2 = 3; #1;
    check("byp.a1", {32'h0, ifa.rdata1}, 64'h5678);
    check("byp.a2", {32'h0, ifa.rdata2}, 64'h5678);
    check("nobyp.b1", {32'h0, ifb.rdata1}, 64'h0);
    check("nobyp.b2", {32'h0, ifb.rdata2}, 64'h0);
    cycle();
    we = 0; #1;
    check("nobyp_next.b1", {32'h0, ifb.rdata1}, 64'h5678);
    check("byp_next.a2", {32'h0, ifa.rdata2}, 64'h5678);

    wr(25, 32'hCAFEF00D, 4'hF);
    wr(19, 32'hCAFEF00D, 4'hF);
    r1 = 25; r2 = 19; #1;
    check("oor.b25", {32'h0, ifb.rdata1}, 64'h0);
    check("oor.b19", {32'h0, ifb.rdata2}, 64'hCAFEF00D);
    for (int i = 0; i < 32; i++) begin
      r1 = 5'(i); r2 = 5'(i); #1;
      check_all("sweep");
    end

    cwe = 1; cwaddr = 6; cwdata = 64'h0123456789ABCDEF; cwstrb = 8'hF0; cr1 = 6; cr2 = 6; #1;
    check("w64_byp", ifc.rdata2, 64'h0123456700000000);
    cycle();
    cwe = 0; #1;
    check("w64", ifc.rdata1, 64'h0123456700000000);

    for (int n = 0; n < 600; n++) begin
      we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom; wstrb = 4'($urandom);
      r1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      r2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
      cwe = 1'($urandom); cwaddr = 3'($urandom); cwdata = {$urandom, $urandom}; cwstrb = 8'($urandom);
      cr1 = ($urandom_range(0, 2) == 0) ? cwaddr : 3'($urandom);
      cr2 = ($urandom_range(0, 2) == 0) ? cwaddr : 3'($urandom);
      #1 check_all("rand");
      if ($urandom_range(0, 39) == 0) begin
        rst = 1;
        clear_model();
        #1 check_all("rand_rst");
        #1 rst = 0;
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
